edge_to_pulse: RTL and testbench

//   Destination-domain end of the toggle CDC link. Synchronises an asynchronous

---
 rtl/cdc_pkg.sv | 7 +
 rtl/sync_ff.sv | 20 ++
 rtl/edge_to_pulse.sv | 107 ++++++++++
 tb/tb_edge_to_pulse.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// cdc_pkg: shared state encoding and limits for the toggle CDC link
package cdc_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, PULSE = 2'd1, GAP = 2'd2} e2p_state_t;
  localparam int MIN_SYNC_STAGES = 2;
  localparam int MAX_SYNC_STAGES = 4;
  localparam int MAX_PULSE_CYCLES = 255;
endpackage

// File: rtl/sync_ff.sv
// sync_ff: STAGES-deep level synchroniser, async active-low reset to 0
//   clk, reset_n : destination clock and reset
//   d            : asynchronous input level
//   q            : synchronised level, STAGES clocks later
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;
  always_comb sync_d = {sync_q[STAGES-2:0], d};
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sync_q <= '0;
    else sync_q <= sync_d;
  assign q = sync_q[STAGES-1];
endmodule

// File: rtl/edge_to_pulse.sv
// edge_to_pulse: destination end of a toggle CDC link, regenerating each source toggle as a pulse
//   clk, reset_n : destination clock, async active-low reset
//   signal       : asynchronous toggle from the source, one event per level change
//   clear_count  : synchronous clear of event_count and overrun
//   pulse        : regenerated pulse, PULSE_CYCLES wide, polarity per ACTIVE_LOW
//   ack_toggle   : inverts when each pulse starts
//   busy         : pulse/gap in progress or an event pending
//   event_count  : saturating count of detected events
//   overrun      : sticky, an event was dropped
module edge_to_pulse
  import cdc_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int PULSE_CYCLES = 1,
  parameter bit ACTIVE_LOW   = 1'b0,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   signal,
  input  logic                   clear_count,
  output logic                   pulse,
  output logic                   ack_toggle,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] event_count,
  output logic                   overrun
);
  localparam int CW = $clog2(PULSE_CYCLES + 1) > 0 ? $clog2(PULSE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(PULSE_CYCLES - 1);
  localparam logic ON = ~ACTIVE_LOW;
  if (SYNC_STAGES < MIN_SYNC_STAGES || SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad_sync
    $error("edge_to_pulse: SYNC_STAGES out of range 2..4");
  end
  if (PULSE_CYCLES < 1 || PULSE_CYCLES > MAX_PULSE_CYCLES) begin : g_bad_pulse
    $error("edge_to_pulse: PULSE_CYCLES out of range 1..255");
  end
  logic sync_lvl, edge_det, start, drop;
  logic prev_q, prev_d, pulse_q, pulse_d, ack_q, ack_d;
  logic pending_q, pending_d, overrun_q, overrun_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  e2p_state_t state_q, state_d;
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .reset_n(reset_n),
    .d(signal),
    .q(sync_lvl)
  );
  always_comb begin
    edge_det = sync_lvl ^ prev_q;
    prev_d = sync_lvl;
    start = 1'b0;
    drop = 1'b0;
    state_d = state_q;
    cnt_d = cnt_q;
    pending_d = pending_q;
    case (state_q)
      IDLE: start = edge_det;
      PULSE: begin
        state_d = cnt_q == '0 ? GAP : PULSE;
        cnt_d = cnt_q - CW'(1);
        drop = edge_det & pending_q;
        pending_d = pending_q | edge_det;
      end
      // a pending event is served first; a coinciding new edge takes its slot
      GAP: begin
        start = pending_q | edge_det;
        pending_d = pending_q & edge_det;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (start) begin
      state_d = PULSE;
      cnt_d = CNT_INIT;
    end
    ack_d = ack_q ^ start;
    pulse_d = state_d == PULSE ? ON : ~ON;
    count_d = clear_count ? COUNT_WIDTH'(edge_det) : count_q + COUNT_WIDTH'(edge_det & ~&count_q);
    overrun_d = drop | (overrun_q & ~clear_count);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      prev_q <= 1'b0;
      state_q <= IDLE;
      cnt_q <= '0;
      pulse_q <= ~ON;
      ack_q <= 1'b0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      count_q <= '0;
    end else begin
      prev_q <= prev_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
      pulse_q <= pulse_d;
      ack_q <= ack_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      count_q <= count_d;
    end
  assign pulse = pulse_q;
  assign ack_toggle = ack_q;
  assign busy = (state_q != IDLE) | pending_q;
  assign event_count = count_q;
  assign overrun = overrun_q;
endmodule

// File: tb/tb_edge_to_pulse.sv
// tb_edge_to_pulse: directed and randomized checks of edge_to_pulse against an event-schedule model
module tb_edge_to_pulse;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [2:0] sig = '0;
  logic [2:0] clr = '0;
  logic [2:0] pls, ack, bsy, ovr;
  logic [15:0] cnt_a, cnt_b;
  logic [3:0] cnt_c;
  int total = 0, bad = 0, cyc = 0, sel = 0, pc = 1, al = 0, cmax = 65535;
  int starts[$];
  int reqs[$];
  int mcnt = 0;
  bit movr = 1'b0;
  always #5 clk = ~clk;
  edge_to_pulse u_a (
    .clk(clk), .reset_n(reset_n), .signal(sig[0]), .clear_count(clr[0]), .pulse(pls[0]),
    .ack_toggle(ack[0]), .busy(bsy[0]), .event_count(cnt_a), .overrun(ovr[0])
  );
  edge_to_pulse #(.PULSE_CYCLES(4), .ACTIVE_LOW(1'b1)) u_b (
    .clk(clk), .reset_n(reset_n), .signal(sig[1]), .clear_count(clr[1]), .pulse(pls[1]),
    .ack_toggle(ack[1]), .busy(bsy[1]), .event_count(cnt_b), .overrun(ovr[1])
  );
  edge_to_pulse #(.COUNT_WIDTH(4)) u_c (
    .clk(clk), .reset_n(reset_n), .signal(sig[2]), .clear_count(clr[2]), .pulse(pls[2]),
    .ack_toggle(ack[2]), .busy(bsy[2]), .event_count(cnt_c), .overrun(ovr[2])
  );
  function automatic logic [19:0] obs();
    logic [15:0] c = sel == 0 ? cnt_a : sel == 1 ? cnt_b : {12'd0, cnt_c};
    return {pls[sel], ack[sel], bsy[sel], ovr[sel], c};
  endfunction
  // each accepted event owns a pulse [s, s+pc-1] followed by one gap cycle
  function automatic logic [19:0] expv();
    int n = 0;
    bit on = 1'b0, bz = 1'b0;
    foreach (starts[i]) begin
      if (starts[i] <= cyc) n++;
      if (starts[i] <= cyc && cyc < starts[i] + pc) on = 1'b1;
      if (starts[i] <= cyc && cyc <= starts[i] + pc) bz = 1'b1;
    end
    return {on ^ al[0], n[0], bz, movr, 16'(mcnt)};
  endfunction
  task automatic choose(input int s);
    sel = s;
    pc = s == 1 ? 4 : 1;
    al = s == 1 ? 1 : 0;
    cmax = s == 2 ? 15 : 65535;
  endtask
  task automatic model_clear();
    starts.delete();
    reqs.delete();
    mcnt = 0;
    movr = 1'b0;
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    sig = '0;
    clr = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask
  // an event seen at edge r starts at r, or right after the previous pulse's gap; dropped if one already waits
  task automatic tick();
    bit ev, drop;
    int last;
    @(posedge clk);
    cyc++;
    ev = reqs.size() > 0 && reqs[0] == cyc;
    if (ev) void'(reqs.pop_front());
    last = starts.size() > 0 ? starts[$] : -1000;
    drop = ev && last > cyc;
    if (ev && !drop) starts.push_back(last + pc + 1 > cyc ? last + pc + 1 : cyc);
    if (clr[sel]) mcnt = ev ? 1 : 0;
    else if (ev && mcnt < cmax) mcnt++;
    movr = clr[sel] ? drop : movr | drop;
    #1;
  endtask
  task automatic toggle();
    sig[sel] = ~sig[sel];
    reqs.push_back(cyc + 3);
  endtask
  task automatic test_reset();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      choose(s);
      total++;
      if (obs() !== {al[0], 19'd0}) begin
        bad++;
        $display("FAIL reset inst=%0d got=%h exp=%h", s, obs(), {al[0], 19'd0});
      end
    end
    do_reset();
  endtask
  task automatic test_single();
    choose(0);
    do_reset();
    toggle();
    for (int i = 1; i <= 8; i++) begin
      tick();
      total++;
      if (obs() !== expv()) begin
        bad++;
        $display("FAIL single_model i=%0d got=%h exp=%h", i, obs(), expv());
      end
      total++;
      if (pls[0] !== (i == 3)) begin
        bad++;
        $display("FAIL single_pulse i=%0d got=%b exp=%b", i, pls[0], i == 3);
      end
    end
    total++;
    if (ack[0] !== 1'b1 || cnt_a !== 16'd1) begin
      bad++;
      $display("FAIL single_final ack=%b cnt=%0d exp ack=1 cnt=1", ack[0], cnt_a);
    end
  endtask
  task automatic test_active_low();
    int lows = 0;
    choose(1);
    do_reset();
    toggle();
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (pls[1] === 1'b0) lows++;
      total++;
      if (obs() !== expv()) begin
        bad++;
        $display("FAIL active_low_model i=%0d got=%h exp=%h", i, obs(), expv());
      end
    end
    total++;
    if (lows != 4) begin
      bad++;
      $display("FAIL active_low_width got=%0d exp=4", lows);
    end
  endtask
  task automatic test_back_to_back();
    int lows = 0, falls = 0;
    logic prev_p = 1'b1;
    choose(1);
    do_reset();
    toggle();
    for (int i = 1; i <= 18; i++) begin
      tick();
      if (pls[1] === 1'b0) lows++;
      if (prev_p === 1'b1 && pls[1] === 1'b0) falls++;
      prev_p = pls[1];
      total++;
      if (obs() !== expv()) begin
        bad++;
        $display("FAIL b2b_model i=%0d got=%h exp=%h", i, obs(), expv());
      end
      if (i == 2) toggle();
    end
    total++;
    if (lows != 8 || falls != 2 || ovr[1] !== 1'b0 || cnt_b !== 16'd2) begin
      bad++;
      $display("FAIL b2b_final lows=%0d pulses=%0d ovr=%b cnt=%0d exp 8 2 0 2", lows, falls, ovr[1], cnt_b);
    end
  endtask
  task automatic test_overrun();
    int falls = 0;
    logic prev_p = 1'b1;
    choose(1);
    do_reset();
    toggle();
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (prev_p === 1'b1 && pls[1] === 1'b0) falls++;
      prev_p = pls[1];
      total++;
      if (obs() !== expv()) begin
        bad++;
        $display("FAIL overrun_model i=%0d got=%h exp=%h", i, obs(), expv());
      end
      if (i <= 2) toggle();
    end
    total++;
    if (falls != 2 || ovr[1] !== 1'b1 || cnt_b !== 16'd3) begin
      bad++;
      $display("FAIL overrun_final pulses=%0d ovr=%b cnt=%0d exp 2 1 3", falls, ovr[1], cnt_b);
    end
    clr[1] = 1'b1;
    tick();
    clr[1] = 1'b0;
    total++;
    if (cnt_b !== 16'd0 || ovr[1] !== 1'b0 || obs() !== expv()) begin
      bad++;
      $display("FAIL overrun_clear cnt=%0d ovr=%b exp cnt=0 ovr=0", cnt_b, ovr[1]);
    end
  endtask
  task automatic test_saturate();
    choose(2);
    do_reset();
    for (int n = 0; n < 17; n++) begin
      toggle();
      repeat (3) begin
        tick();
        total++;
        if (obs() !== expv()) begin
          bad++;
          $display("FAIL saturate_model n=%0d got=%h exp=%h", n, obs(), expv());
        end
      end
    end
    repeat (3) tick();
    total++;
    if (cnt_c !== 4'd15) begin
      bad++;
      $display("FAIL saturate_count got=%0d exp=15", cnt_c);
    end
    toggle();
    tick();
    tick();
    clr[2] = 1'b1;
    tick();
    clr[2] = 1'b0;
    total++;
    if (cnt_c !== 4'd1 || obs() !== expv()) begin
      bad++;
      $display("FAIL clear_with_edge got=%0d exp=1", cnt_c);
    end
  endtask
  task automatic test_reset_mid();
    choose(1);
    do_reset();
    toggle();
    tick();
    toggle();
    repeat (3) tick();
    total++;
    if (obs() !== expv() || pls[1] !== 1'b0 || bsy[1] !== 1'b1) begin
      bad++;
      $display("FAIL mid_before got=%h exp=%h", obs(), expv());
    end
    reset_n = 1'b0;
    sig = '0;
    model_clear();
    #1;
    total++;
    if (obs() !== 20'h80000) begin
      bad++;
      $display("FAIL mid_async got=%h exp=%h", obs(), 20'h80000);
    end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      total++;
      if (pls[1] !== 1'b1 || obs() !== expv()) begin
        bad++;
        $display("FAIL mid_quiet i=%0d got=%h exp=%h", i, obs(), expv());
      end
    end
    toggle();
    for (int i = 1; i <= 8; i++) begin
      tick();
      total++;
      if (obs() !== expv()) begin
        bad++;
        $display("FAIL mid_after i=%0d got=%h exp=%h", i, obs(), expv());
      end
    end
  endtask
  task automatic test_random();
    for (int s = 0; s < 3; s++) begin
      choose(s);
      do_reset();
      for (int i = 0; i < 300; i++) begin
        if ($urandom_range(2) == 0) toggle();
        clr[sel] = $urandom_range(19) == 0;
        tick();
        total++;
        if (obs() !== expv()) begin
          bad++;
          $display("FAIL random inst=%0d i=%0d got=%h exp=%h", s, i, obs(), expv());
        end
      end
      clr = '0;
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_active_low();
    test_back_to_back();
    test_overrun();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
